// File: rtl/mips_ctrl_pkg.sv
// Shared control types for the multicycle MIPS core: sequencer states and the
// instruction classes the decoder hands to the sequencer.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    EXEC1   = 3'd1,
    EXEC2   = 3'd2,
    HALT    = 3'd3,
    MD_WAIT = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    IC_ALU    = 3'd0,
    IC_LOAD   = 3'd1,
    IC_STORE  = 3'd2,
    IC_BRANCH = 3'd3,
    IC_JUMP   = 3'd4,
    IC_MULDIV = 3'd5
  } iclass_t;

  // Control-flow classes are the only ones that can open a delay slot.
  function automatic logic is_flow(iclass_t c);
    return (c == IC_BRANCH) || (c == IC_JUMP);
  endfunction

endpackage

// File: rtl/mips_sequencer_if.sv
// Bundle between the sequencer (master) and the decoder/memory/datapath side (slave).
interface mips_sequencer_if
  import mips_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) ();
  iclass_t             instr_class;
  logic                reg_write_req;
  logic                branch_taken;
  logic [ADDR_W-1:0]   branch_target;
  logic                halt_req;
  logic                waitrequest;
  state_t              state;
  logic                active;
  logic                mem_read;
  logic                mem_write;
  logic                ir_load;
  logic                pc_en;
  logic                pc_sel;
  logic [ADDR_W-1:0]   pc_target;
  logic                reg_write_en;
  logic                muldiv_busy;
  logic                delay_slot;

  modport master (
    input  instr_class, reg_write_req, branch_taken, branch_target, halt_req, waitrequest,
    output state, active, mem_read, mem_write, ir_load, pc_en, pc_sel, pc_target,
           reg_write_en, muldiv_busy, delay_slot
  );

  modport slave (
    output instr_class, reg_write_req, branch_taken, branch_target, halt_req, waitrequest,
    input  state, active, mem_read, mem_write, ir_load, pc_en, pc_sel, pc_target,
           reg_write_en, muldiv_busy, delay_slot
  );
endinterface

// File: rtl/mips_lat_counter.sv
// Loadable down-counter timing the MULT/DIV wait; stops at zero rather than wrapping.
module mips_lat_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n)           cnt_q <= '0;
    else if (load)          cnt_q <= load_val;
    else if (dec && !zero)  cnt_q <= cnt_q - 1'b1;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/mips_sequencer.sv
// Multicycle control sequencer: fetch/execute FSM with Avalon stalls, MULT/DIV
// wait, delay-slot redirect tracking and an absorbing HALT.
module mips_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MULDIV_LAT = 32,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  mips_sequencer_if.master bus
);
  state_t              state_q, state_d;
  logic                pending_q;
  logic [ADDR_W-1:0]   pc_target_q;
  logic                mem_read, mem_write, ir_load, pc_en, reg_write_en, muldiv_busy;
  logic                cnt_load, cnt_dec, cnt_zero, take_br;

  mips_lat_counter #(.CNT_W(CNT_W)) u_lat (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (CNT_W'(MULDIV_LAT - 1)),
    .zero     (cnt_zero)
  );

  // Strobes are gated by reset so an asserted reset_n=0 quiets the bus immediately.
  always_comb begin
    state_d      = state_q;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_load      = 1'b0;
    pc_en        = 1'b0;
    reg_write_en = 1'b0;
    muldiv_busy  = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    if (reset_n) begin
      case (state_q)
        FETCH: begin
          if (bus.halt_req) state_d = HALT;
          else begin
            mem_read = 1'b1;
            if (!bus.waitrequest) begin
              ir_load = 1'b1;
              state_d = EXEC1;
            end
          end
        end
        EXEC1: begin
          case (bus.instr_class)
            IC_LOAD: begin
              mem_read = 1'b1;
              if (!bus.waitrequest) state_d = EXEC2;
            end
            IC_STORE: begin
              mem_write = 1'b1;
              if (!bus.waitrequest) begin
                pc_en   = 1'b1;
                state_d = FETCH;
              end
            end
            IC_MULDIV: begin
              cnt_load = 1'b1;
              state_d  = MD_WAIT;
            end
            default: begin
              reg_write_en = bus.reg_write_req;
              pc_en        = 1'b1;
              state_d      = FETCH;
            end
          endcase
        end
        EXEC2: begin
          reg_write_en = 1'b1;
          pc_en        = 1'b1;
          state_d      = FETCH;
        end
        MD_WAIT: begin
          muldiv_busy = 1'b1;
          cnt_dec     = 1'b1;
          if (cnt_zero) begin
            pc_en        = 1'b1;
            reg_write_en = bus.reg_write_req;
            state_d      = FETCH;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = FETCH;
      endcase
    end
  end

  assign take_br = (state_q == EXEC1) && is_flow(bus.instr_class) && bus.branch_taken;

  // A taken branch in a slot still consumes the old redirect on this pc_en,
  // then arms its own redirect for after its own slot.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= FETCH;
      pending_q   <= 1'b0;
      pc_target_q <= '0;
    end else begin
      state_q <= state_d;
      if (pc_en) begin
        if (take_br) begin
          pc_target_q <= bus.branch_target;
          pending_q   <= 1'b1;
        end else begin
          pending_q   <= 1'b0;
        end
      end
    end
  end

  assign bus.state        = state_q;
  assign bus.active       = (state_q != HALT);
  assign bus.mem_read     = mem_read;
  assign bus.mem_write    = mem_write;
  assign bus.ir_load      = ir_load;
  assign bus.pc_en        = pc_en;
  assign bus.pc_sel       = pc_en && pending_q;
  assign bus.pc_target    = pc_target_q;
  assign bus.reg_write_en = reg_write_en;
  assign bus.muldiv_busy  = muldiv_busy;
  assign bus.delay_slot   = pending_q;
endmodule

// File: tb/tb_mips_sequencer.sv
// Scoreboard bench: stimulus queues expected pc_en events and output probes,
// a negedge monitor pops and compares them.
module tb_mips_sequencer;
  import mips_ctrl_pkg::*;

  localparam int LAT_A = 4;
  localparam int LAT_B = 1;

  typedef struct {
    state_t      st;
    logic        rwe;
    logic        sel;
    logic        ds;
    logic [31:0] tgt;
    int          gap;
    int          rd;
    int          wr;
    int          ir;
    int          busy;
  } ev_t;

  typedef struct {
    logic [9:0]  v;
    logic [31:0] tgt;
  } pr_t;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  logic done = 1'b0;
  always #5 clk = ~clk;

  mips_sequencer_if #(.ADDR_W(32)) ia ();
  mips_sequencer_if #(.ADDR_W(32)) ib ();

  mips_sequencer #(.ADDR_W(32), .MULDIV_LAT(LAT_A), .CNT_W(6)) dut_a (
    .clk(clk), .reset_n(rst_a_n), .bus(ia.master));
  mips_sequencer #(.ADDR_W(32), .MULDIV_LAT(LAT_B), .CNT_W(6)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .bus(ib.master));

  ev_t qa[$];
  ev_t qb[$];
  pr_t pq[$];
  logic        m_pend = 1'b0;
  logic [31:0] m_tgt  = '0;

  int n_checks = 0;
  int n_errs   = 0;
  int gap_a = 0, rd_a = 0, wr_a = 0, ir_a = 0, bz_a = 0;
  int gap_b = 0, bz_b = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: window counters between pc_en events, compare on each event/probe.
  always @(negedge clk) begin
    ev_t e;
    pr_t p;
    if (!rst_a_n) begin
      gap_a = 0; rd_a = 0; wr_a = 0; ir_a = 0; bz_a = 0;
    end else begin
      gap_a++;
      rd_a += int'(ia.mem_read);
      wr_a += int'(ia.mem_write);
      ir_a += int'(ia.ir_load);
      bz_a += int'(ia.muldiv_busy);
      if (ia.pc_en) begin
        if (qa.size() == 0) chk("a_unexpected_pc_en", 1, 0);
        else begin
          e = qa.pop_front();
          chk("a_state",  ia.state, e.st);
          chk("a_rwe",    ia.reg_write_en, e.rwe);
          chk("a_pc_sel", ia.pc_sel, e.sel);
          chk("a_tgt",    ia.pc_target, e.tgt);
          chk("a_dslot",  ia.delay_slot, e.ds);
          chk("a_gap",    gap_a, e.gap);
          chk("a_rd",     rd_a, e.rd);
          chk("a_wr",     wr_a, e.wr);
          chk("a_ir",     ir_a, e.ir);
          chk("a_busy",   bz_a, e.busy);
        end
        gap_a = 0; rd_a = 0; wr_a = 0; ir_a = 0; bz_a = 0;
      end
    end
    if (pq.size() != 0) begin
      p = pq.pop_front();
      chk("probe_vec", {ia.state, ia.active, ia.mem_read, ia.mem_write, ia.ir_load,
                        ia.pc_en, ia.muldiv_busy, ia.delay_slot}, p.v);
      chk("probe_tgt", ia.pc_target, p.tgt);
    end
    if (!rst_b_n) begin
      gap_b = 0; bz_b = 0;
    end else begin
      gap_b++;
      bz_b += int'(ib.muldiv_busy);
      if (ib.pc_en) begin
        if (qb.size() == 0) chk("b_unexpected_pc_en", 1, 0);
        else begin
          e = qb.pop_front();
          chk("b_state", ib.state, e.st);
          chk("b_rwe",   ib.reg_write_en, e.rwe);
          chk("b_gap",   gap_b, e.gap);
          chk("b_busy",  bz_b, e.busy);
        end
        gap_b = 0; bz_b = 0;
      end
    end
    if (done) begin
      chk("a_queue_drained", qa.size(), 0);
      chk("b_queue_drained", qb.size(), 0);
      chk("probe_queue_drained", pq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
    end
  end

  task automatic cyc(input logic w);
    ia.waitrequest = w;
    @(posedge clk); #1;
  endtask

  task automatic probe(input state_t s, input logic act, input logic rd, input logic wr,
                       input logic ir, input logic pe, input logic bz, input logic ds,
                       input logic [31:0] tg);
    pr_t p;
    p.v   = {s, act, rd, wr, ir, pe, bz, ds};
    p.tgt = tg;
    pq.push_back(p);
  endtask

  // Issue one instruction on DUT A: fws fetch stalls, dws data stalls.
  task automatic do_instr(input iclass_t c, input logic rwr, input logic tk,
                          input logic [31:0] tg, input int fws, input int dws);
    ev_t e;
    e.sel = m_pend; e.ds = m_pend; e.tgt = m_tgt;
    e.st = EXEC1; e.rwe = rwr; e.gap = fws + 2;
    e.rd = fws + 1; e.wr = 0; e.ir = 1; e.busy = 0;
    case (c)
      IC_LOAD:   begin e.gap = fws + dws + 3; e.rd = fws + dws + 2; e.st = EXEC2; e.rwe = 1'b1; end
      IC_STORE:  begin e.gap = fws + dws + 2; e.wr = dws + 1; e.rwe = 1'b0; end
      IC_MULDIV: begin e.gap = fws + 2 + LAT_A; e.busy = LAT_A; e.st = MD_WAIT; end
      default: ;
    endcase
    if ((c == IC_BRANCH || c == IC_JUMP) && tk) begin m_tgt = tg; m_pend = 1'b1; end
    else m_pend = 1'b0;
    qa.push_back(e);
    ia.instr_class = c; ia.reg_write_req = rwr; ia.branch_taken = tk;
    ia.branch_target = tg; ia.halt_req = 1'b0;
    repeat (fws) cyc(1'b1);
    cyc(1'b0);
    case (c)
      IC_LOAD:   begin repeat (dws) cyc(1'b1); cyc(1'b0); cyc(1'b0); end
      IC_STORE:  begin repeat (dws) cyc(1'b1); cyc(1'b0); end
      IC_MULDIV: repeat (LAT_A + 1) cyc(1'b0);
      default:   cyc(1'b0);
    endcase
  endtask

  initial begin
    ev_t eb;
    ia.instr_class = IC_ALU; ia.reg_write_req = 1'b0; ia.branch_taken = 1'b0;
    ia.branch_target = '0; ia.halt_req = 1'b0; ia.waitrequest = 1'b0;
    ib.instr_class = IC_MULDIV; ib.reg_write_req = 1'b1; ib.branch_taken = 1'b0;
    ib.branch_target = '0; ib.halt_req = 1'b0; ib.waitrequest = 1'b0;

    repeat (2) begin @(posedge clk); #1; end
    probe(FETCH, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    @(posedge clk); #1;
    rst_a_n = 1'b1;

    do_instr(IC_ALU,    1, 0, 32'h0,   3, 0);
    do_instr(IC_LOAD,   1, 0, 32'h0,   0, 2);
    do_instr(IC_STORE,  1, 0, 32'h0,   1, 1);
    do_instr(IC_MULDIV, 1, 0, 32'h0,   0, 0);
    do_instr(IC_BRANCH, 0, 1, 32'h40,  0, 0);
    do_instr(IC_ALU,    1, 0, 32'h0,   1, 0);
    do_instr(IC_ALU,    0, 0, 32'h0,   0, 0);
    do_instr(IC_JUMP,   1, 1, 32'h100, 0, 0);
    do_instr(IC_BRANCH, 0, 1, 32'h200, 0, 0);
    do_instr(IC_LOAD,   1, 0, 32'h0,   0, 1);
    do_instr(IC_JUMP,   0, 1, 32'h80,  0, 0);
    do_instr(IC_BRANCH, 0, 0, 32'h300, 0, 0);
    do_instr(IC_BRANCH, 0, 0, 32'h300, 0, 0);

    // MULDIV in a taken-branch slot, reset in its second MD_WAIT cycle.
    do_instr(IC_BRANCH, 0, 1, 32'h44, 0, 0);
    ia.instr_class = IC_MULDIV; ia.branch_taken = 1'b0; ia.reg_write_req = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    probe(MD_WAIT, 1, 0, 0, 0, 0, 1, 1, 32'h44);
    cyc(1'b0);
    rst_a_n = 1'b0;
    probe(MD_WAIT, 1, 0, 0, 0, 0, 0, 1, 32'h44);
    @(posedge clk); #1;
    probe(FETCH, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    @(posedge clk); #1;
    m_pend = 1'b0; m_tgt = '0;
    rst_a_n = 1'b1;

    ia.halt_req = 1'b1; ia.waitrequest = 1'b0;
    probe(FETCH, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    @(posedge clk); #1;
    repeat (100) begin
      ia.waitrequest = 1'($urandom_range(0, 1));
      ia.halt_req    = 1'($urandom_range(0, 1));
      ia.instr_class = iclass_t'($urandom_range(0, 5));
      probe(HALT, 0, 0, 0, 0, 0, 0, 0, 32'h0);
      @(posedge clk); #1;
    end

    eb.st = MD_WAIT; eb.rwe = 1'b1; eb.gap = 3; eb.busy = LAT_B;
    eb.sel = 1'b0; eb.ds = 1'b0; eb.tgt = '0; eb.rd = 0; eb.wr = 0; eb.ir = 0;
    qb.push_back(eb);
    rst_b_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    ib.halt_req = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errs);
    $fatal(1);
  end
endmodule
